vga_out_stage: RTL

- Final output stage sitting directly downstream of the VGA sync generator; drives the physical VGA pins.
- Delays the generator's sync and visible strobes so they line up with the colour pipeline latency.
- Registers sync and colour outputs, applies blanking and configurable sync polarity.
- Produces a per-frame tick and a frame counter for the render logic (animation and vertical-blank housekeeping).

---
 rtl/vga_out_pkg.sv | 45 ++++
 rtl/vga_delay_line.sv | 35 +++
 rtl/vga_out_stage.sv | 101 ++++++++++
 3 files changed

// File: rtl/vga_out_pkg.sv
// Shared types and constants for the VGA output stage.
package vga_out_pkg;

    localparam int unsigned R_W   = 2;
    localparam int unsigned G_W   = 2;
    localparam int unsigned B_W   = 2;
    localparam int unsigned RGB_W = R_W + G_W + B_W;

    localparam int unsigned TESTPAT_BAR_W = 80;
    localparam int unsigned TESTPAT_BARS  = 8;
    localparam int unsigned COL_W         = 10;
    localparam int unsigned BAR_IDX_W     = 3;

    typedef logic [RGB_W-1:0] rgb_t;

    localparam rgb_t COLOR_BLACK = 6'h00;
    localparam rgb_t COLOR_WHITE = 6'h3F;

    // Sync-generator strobes that travel together through the delay line.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic visible;
        logic frame_end;
    } strobe_t;

    localparam int unsigned STROBE_W = $bits(strobe_t);

    // Colour-bar table: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic rgb_t bar_color(input logic [BAR_IDX_W-1:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = COLOR_WHITE;
            3'd1:    c = 6'h3C;
            3'd2:    c = 6'h0F;
            3'd3:    c = 6'h0C;
            3'd4:    c = 6'h33;
            3'd5:    c = 6'h30;
            3'd6:    c = 6'h03;
            default: c = COLOR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with async active-high reset; DEPTH=0 is a wire.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        stage[i] <= '0;
                    end
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        stage[i] <= stage[i-1];
                    end
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_out_stage.sv
// VGA pin driver: aligns sync strobes with the colour pipeline, blanks, sets sync
// polarity and counts frames. Define VGA_OUT_TESTPAT_EN to add the colour-bar generator.
module vga_out_stage
    import vga_out_pkg::*;
#(
    parameter int unsigned PIPE_DEPTH = 2,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0,
    parameter int unsigned FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               visible_in,
    input  logic               hmax_in,
    input  logic               vmax_in,
    input  logic [RGB_W-1:0]   rgb_in,
`ifdef VGA_OUT_TESTPAT_EN
    input  logic               test_en,
`endif
    output logic               hsync,
    output logic               vsync,
    output logic [RGB_W-1:0]   rgb,
    output logic               frame_tick,
    output logic [FRAME_W-1:0] frame_count
);

    strobe_t strobe_in;
    strobe_t strobe_dly;
    rgb_t    pixel_c;

    assign strobe_in = {hsync_in, vsync_in, visible_in, hmax_in & vmax_in};

    vga_delay_line #(
        .WIDTH (STROBE_W),
        .DEPTH (PIPE_DEPTH)
    ) u_strobe_dly (
        .clk   (clk),
        .reset (reset),
        .din   (strobe_in),
        .dout  (strobe_dly)
    );

`ifdef VGA_OUT_TESTPAT_EN
    logic [COL_W-1:0]     col;
    logic [COL_W-1:0]     bar_full_c;
    logic [BAR_IDX_W-1:0] bar_idx_c;

    // Column position within the current visible run of the delayed strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col <= '0;
        end else if (strobe_dly.visible) begin
            col <= col + COL_W'(1);
        end else begin
            col <= '0;
        end
    end

    // Columns past the last bar stay on the final (black) entry.
    always_comb begin
        bar_full_c = col / COL_W'(TESTPAT_BAR_W);
        bar_idx_c  = BAR_IDX_W'(TESTPAT_BARS - 1);
        if (bar_full_c < COL_W'(TESTPAT_BARS)) begin
            bar_idx_c = bar_full_c[BAR_IDX_W-1:0];
        end
    end

    always_comb begin
        pixel_c = rgb_in;
        if (test_en) begin
            pixel_c = bar_color(bar_idx_c);
        end
    end
`else
    always_comb begin
        pixel_c = rgb_in;
    end
`endif

    // Output register; reset drives syncs to their inactive level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync       <= ~H_SYNC_POL;
            vsync       <= ~V_SYNC_POL;
            rgb         <= COLOR_BLACK;
            frame_tick  <= 1'b0;
            frame_count <= '0;
        end else begin
            hsync      <= strobe_dly.hsync ~^ H_SYNC_POL;
            vsync      <= strobe_dly.vsync ~^ V_SYNC_POL;
            rgb        <= strobe_dly.visible ? pixel_c : COLOR_BLACK;
            frame_tick <= strobe_dly.frame_end;
            if (frame_tick) begin
                frame_count <= frame_count + FRAME_W'(1);
            end
        end
    end

endmodule
